// File: rtl/tx_fcs_append.sv
// Transmit-side FCS generator: forwards frame bytes, zero-pads to MIN_LEN and
// appends the Ethernet CRC-32, through a single registered output stage.
module tx_fcs_append #(
    parameter int MIN_LEN = 60
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] IN_DATA,
    input  logic       IN_VALID,
    input  logic       IN_LAST,
    output logic       IN_READY,
    output logic [7:0] OUT_DATA,
    output logic       OUT_VALID,
    output logic       OUT_LAST,
    input  logic       OUT_READY,
    output logic       BUSY
);

    typedef enum logic [1:0] {IDLE, DATA, PAD, FCS} state_t;

    state_t      state;
    logic [31:0] crc;
    logic [15:0] byte_cnt;
    logic [1:0]  fcs_idx;

    logic        slot_free;
    logic        in_xfer;
    logic [15:0] cnt_inc;
    logic [31:0] fcs_shift;
    logic [7:0]  fcs_byte;

    // Reflected LSB-first shift; identical to the D[7]-first update applied
    // to the bit-reversed byte, without the explicit reversals.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign slot_free = !OUT_VALID || OUT_READY;
    // NOTE: IN_READY is combinational, so it is gated by RESET_N to stay low
    // while reset is held even though the output slot reads as free.
    assign IN_READY  = RESET_N && slot_free && (state == IDLE || state == DATA);
    assign in_xfer   = IN_VALID && IN_READY;
    assign cnt_inc   = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
    assign fcs_shift = ~crc >> {fcs_idx, 3'b000};
    assign fcs_byte  = fcs_shift[7:0];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            crc       <= 32'hFFFF_FFFF;
            byte_cnt  <= 16'd0;
            fcs_idx   <= 2'd0;
            OUT_DATA  <= 8'h00;
            OUT_VALID <= 1'b0;
            OUT_LAST  <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            if (in_xfer)
                BUSY <= 1'b1;
            else if (OUT_VALID && OUT_READY && OUT_LAST)
                BUSY <= 1'b0;

            if (slot_free) begin
                OUT_VALID <= 1'b0;
                OUT_LAST  <= 1'b0;
                case (state)
                    IDLE, DATA: begin
                        if (IN_VALID) begin
                            OUT_DATA  <= IN_DATA;
                            OUT_VALID <= 1'b1;
                            crc       <= crc32_byte(crc, IN_DATA);
                            byte_cnt  <= cnt_inc;
                            if (!IN_LAST)
                                state <= DATA;
                            else if (int'(cnt_inc) < MIN_LEN)
                                state <= PAD;
                            else
                                state <= FCS;
                        end
                    end
                    PAD: begin
                        OUT_DATA  <= 8'h00;
                        OUT_VALID <= 1'b1;
                        crc       <= crc32_byte(crc, 8'h00);
                        byte_cnt  <= cnt_inc;
                        // Leave on the load that reaches MIN_LEN so the FCS
                        // follows the last pad byte without a bubble.
                        if (int'(cnt_inc) >= MIN_LEN)
                            state <= FCS;
                    end
                    FCS: begin
                        OUT_DATA  <= fcs_byte;
                        OUT_VALID <= 1'b1;
                        OUT_LAST  <= (fcs_idx == 2'd3);
                        fcs_idx   <= fcs_idx + 2'd1;
                        if (fcs_idx == 2'd3) begin
                            state    <= IDLE;
                            crc      <= 32'hFFFF_FFFF;
                            byte_cnt <= 16'd0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_fcs_append.sv
// Scoreboard bench for tx_fcs_append: two instances (MIN_LEN 0 and 60), a
// high-level CRC/padding model feeding per-instance queues, and a monitor.
module tb_tx_fcs_append;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;
    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data;
    logic       in_valid, in_last, out_ready, in_ready;
    int         sel;
    logic       iv0, iv1, rdy0, rdy1, ov0, ov1, ol0, ol1, busy0, busy1;
    logic [7:0] od0, od1;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    bit         or_mode = 1'b0;
    bit         discard = 1'b0;
    bit         rec     = 1'b0;
    exp_t       exp_q[2][$];
    int         rec_cyc[$];
    bit         rec_last[$];
    logic       prev_stall[2];
    logic [7:0] prev_d[2];
    logic       prev_l[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign iv0 = in_valid && (sel == 0);
    assign iv1 = in_valid && (sel == 1);
    assign in_ready = (sel == 0) ? rdy0 : rdy1;

    tx_fcs_append #(.MIN_LEN(0)) u_dut0 (
        .CLK(clk), .RESET_N(rst_n), .IN_DATA(in_data), .IN_VALID(iv0), .IN_LAST(in_last),
        .IN_READY(rdy0), .OUT_DATA(od0), .OUT_VALID(ov0), .OUT_LAST(ol0),
        .OUT_READY(out_ready), .BUSY(busy0));

    tx_fcs_append #(.MIN_LEN(60)) u_dut60 (
        .CLK(clk), .RESET_N(rst_n), .IN_DATA(in_data), .IN_VALID(iv1), .IN_LAST(in_last),
        .IN_READY(rdy1), .OUT_DATA(od1), .OUT_VALID(ov1), .OUT_LAST(ol1),
        .OUT_READY(out_ready), .BUSY(busy1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Textbook MSB-first CRC-32 on reflected input, reflected and inverted at the end.
    function automatic logic [31:0] model_crc(input byte_q_t msg);
        logic [31:0] r;
        logic [31:0] o;
        r = 32'hFFFF_FFFF;
        foreach (msg[i]) begin
            r = r ^ {rev8(msg[i]), 24'h0};
            for (int k = 0; k < 8; k++)
                r = r[31] ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
        end
        for (int i = 0; i < 32; i++) o[i] = r[31-i];
        return ~o;
    endfunction

    task automatic push_frame(input int d, input byte_q_t payload, input int min_len);
        byte_q_t     f;
        logic [31:0] c;
        f = payload;
        while (f.size() < min_len) f.push_back(8'h00);
        c = model_crc(f);
        foreach (f[i]) exp_q[d].push_back('{f[i], 1'b0});
        for (int k = 0; k < 4; k++) exp_q[d].push_back('{c[8*k +: 8], k == 3});
    endtask

    task automatic push_check_string(input int d);
        logic [7:0] ref_bytes[13];
        ref_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                      8'h26, 8'h39, 8'hF4, 8'hCB};
        for (int i = 0; i < 13; i++) exp_q[d].push_back('{ref_bytes[i], i == 12});
    endtask

    function automatic byte_q_t check_string();
        byte_q_t q;
        for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
        return q;
    endfunction

    function automatic byte_q_t rand_payload(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // ---------------- monitor ----------------
    task automatic mon(input int d, input logic v, input logic [7:0] dat, input logic l);
        exp_t e;
        if (prev_stall[d]) begin
            check("stall_valid", 32'(v), 32'd1);
            check("stall_data", 32'(dat), 32'(prev_d[d]));
            check("stall_last", 32'(l), 32'(prev_l[d]));
        end
        if (v && out_ready) begin
            if (discard && d == sel) begin
                check("abort_no_last", 32'(l), 32'd0);
            end else if (exp_q[d].size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out dut%0d: got 0x%0h, expected no byte", d, dat);
            end else begin
                e = exp_q[d].pop_front();
                check($sformatf("out_data dut%0d", d), 32'(dat), 32'(e.data));
                check($sformatf("out_last dut%0d", d), 32'(l), 32'(e.last));
                if (rec && d == 1) begin
                    rec_cyc.push_back(cyc);
                    rec_last.push_back(l);
                end
            end
        end
        prev_stall[d] = v && !out_ready;
        prev_d[d]     = dat;
        prev_l[d]     = l;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall[0] = 1'b0;
            prev_stall[1] = 1'b0;
        end else begin
            mon(0, ov0, od0, ol0);
            mon(1, ov1, od1, ol1);
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready = or_mode ? 1'($urandom_range(1)) : 1'b1;
    end

    // ---------------- driver ----------------
    // Entered and left at posedge+1; abort_after > 0 stops after that many accepts.
    task automatic send(input byte_q_t p, input int gap_pct, input int abort_after);
        for (int i = 0; i < p.size(); i++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_data  = p[i];
            in_last  = (i == p.size() - 1);
            in_valid = 1'b1;
            begin
                int w = 0;
                @(negedge clk);
                while (!in_ready && w < 2000) begin
                    w++;
                    @(negedge clk);
                end
                if (w >= 2000) begin
                    check("in_ready_timeout", 32'(w), 32'd0);
                    in_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            #1;
            if (abort_after == i + 1) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && w < 5000) begin
            @(posedge clk);
            w++;
        end
        if (w >= 5000) check("drain_timeout", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b1; sel = 0;

        // Reset values while RESET_N is held low
        #1;
        check("rst_out_valid", 32'(ov0), 32'd0);
        check("rst_out_data", 32'(od0), 32'd0);
        check("rst_out_last", 32'(ol0), 32'd0);
        check("rst_in_ready", 32'(rdy0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_in_ready60", 32'(rdy1), 32'd0);
        #22 rst_n = 1'b1;
        #1 check("in_ready_after_reset", 32'(rdy0), 32'd1);
        @(posedge clk);
        #1;

        // 1: check string, MIN_LEN=0
        sel = 0;
        push_check_string(0);
        send(check_string(), 0, 0);
        drain();
        check("busy_idle_after_frame", 32'(busy0), 32'd0);

        // 2: single byte, padded to 60
        sel = 1;
        begin
            byte_q_t one;
            int      n = 0;
            one.push_back(8'hAA);
            push_frame(1, one, 60);
            send(one, 0, 0);
            @(negedge clk);
            check("busy_mid_frame", 32'(busy1), 32'd1);
            while (!in_ready && n < 200) begin
                n++;
                @(negedge clk);
            end
            check("pad_ready_low_cycles", 32'(n), 32'd63);
        end
        drain();

        // 3: 64-byte frame, no padding
        push_frame(1, rand_payload(64), 60);
        send(rand_payload(0), 0, 0);
        begin
            byte_q_t p;
            exp_q[1].delete();
            p = rand_payload(64);
            push_frame(1, p, 60);
            send(p, 0, 0);
        end
        drain();

        // 4: check string under random back-pressure
        sel = 0;
        or_mode = 1'b1;
        push_check_string(0);
        send(check_string(), 0, 0);
        drain();
        or_mode = 1'b0;
        @(posedge clk);
        #1;

        // 5: three back-to-back 60-byte frames, continuous flow
        sel = 1;
        rec = 1'b1;
        rec_cyc.delete();
        rec_last.delete();
        for (int f = 0; f < 3; f++) begin
            byte_q_t p;
            p = rand_payload(60);
            push_frame(1, p, 60);
            send(p, 0, 0);
        end
        drain();
        rec = 1'b0;
        check("b2b_count", 32'(rec_cyc.size()), 32'd192);
        if (rec_cyc.size() == 192) begin
            int nl = 0;
            check("b2b_contiguous", 32'(rec_cyc[191] - rec_cyc[0]), 32'd191);
            foreach (rec_last[i]) if (rec_last[i]) nl++;
            check("b2b_last_count", 32'(nl), 32'd3);
            check("b2b_last_pos", {29'd0, rec_last[63], rec_last[127], rec_last[191]}, 32'd7);
        end

        // Random frames on both instances with gaps and back-pressure
        or_mode = 1'b1;
        for (int f = 0; f < 8; f++) begin
            byte_q_t p;
            sel = int'($urandom_range(1));
            p = rand_payload(int'($urandom_range(1, 80)));
            push_frame(sel, p, sel == 0 ? 0 : 60);
            send(p, 20, 0);
        end
        drain();
        or_mode = 1'b0;
        @(posedge clk);
        #1;

        // 6: reset mid-frame, then a clean frame
        sel = 0;
        discard = 1'b1;
        send(rand_payload(20), 0, 5);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(ov0), 32'd0);
        check("midrst_out_data", 32'(od0), 32'd0);
        check("midrst_out_last", 32'(ol0), 32'd0);
        check("midrst_in_ready", 32'(rdy0), 32'd0);
        check("midrst_busy", 32'(busy0), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        discard = 1'b0;
        @(posedge clk);
        #1;
        push_check_string(0);
        send(check_string(), 0, 0);
        drain();

        check("final_busy0", 32'(busy0), 32'd0);
        check("final_busy60", 32'(busy1), 32'd0);
        check("final_queue_empty", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_fcs_append.md
# tx_fcs_append

Transmit-side frame check sequence generator for the 10G MAC tx path. It accepts a frame as a byte stream, forwards it unchanged, and zero-pads it up to a minimum length. It then appends the 4-byte Ethernet CRC-32 FCS. Its output is what the rx-side CRC checker validates at the far end of the link. It sits between the tx frame buffer and the byte-to-XGMII lane packer.

## Interface
Parameters:
- MIN_LEN, 60: minimum pre-FCS frame length in bytes; shorter frames are zero-padded; 0 disables padding

Ports:
- CLK  input  1  single clock; all logic on rising edge
- RESET_N  input  1  asynchronous, active-low reset
- IN_DATA  input  8  frame byte
- IN_VALID  input  1  IN_DATA valid
- IN_LAST  input  1  IN_DATA is the final payload byte of the frame
- IN_READY  output  1  block accepts a byte this cycle
- OUT_DATA  output  8  frame, pad or FCS byte
- OUT_VALID  output  1  OUT_DATA valid
- OUT_LAST  output  1  final FCS byte of the frame
- OUT_READY  input  1  downstream accepts OUT_DATA this cycle
- BUSY  output  1  high from first accepted byte until the last FCS byte is accepted downstream

## Operation
- Transfers: input transfer on IN_VALID & IN_READY; output transfer on OUT_VALID & OUT_READY.
- Output is one register stage. Define `slot_free = !OUT_VALID | OUT_READY`; a byte loads into the output register only when slot_free.
- While OUT_VALID & !OUT_READY, OUT_DATA and OUT_LAST hold stable.
- CRC-32 is standard Ethernet: reflected, polynomial 0x04C11DB7, init 0xFFFFFFFF, final complement. It uses the team's D[7]-first 8-bit update with each byte bit-reversed on entry.
- FCS bytes are emitted least-significant byte of the final value first.
- CRC covers every data and pad byte, updated as each loads into the output register.
- Byte counter: 16-bit, counts loaded data/pad bytes, saturates at 0xFFFF.
- State machine:
  - IDLE: CRC = 0xFFFFFFFF, counter = 0; IN_READY = slot_free. An accepted byte loads and goes to DATA, or, if IN_LAST, follows the end-of-data rule below.
  - DATA: IN_READY = slot_free. Each accepted byte loads. On accepted IN_LAST, go to PAD if counter+1 < MIN_LEN, else to FCS.
  - PAD: IN_READY = 0; load 0x00 whenever slot_free until counter == MIN_LEN, then go to FCS.
  - FCS: IN_READY = 0; load FCS bytes 0..3 on successive slot_free cycles. Byte 3 loads with OUT_LAST = 1, and the state then returns to IDLE.
- Frames are at least 1 byte; IN_LAST on the first byte is legal.
- OUT_LAST is never asserted on data or pad bytes.
- IN_LAST is ignored in PAD and FCS, since IN_READY is low there.

## Timing
- Reset (RESET_N low, asynchronous) forces:
  - OUT_VALID = 0, OUT_DATA = 0x00, OUT_LAST = 0, IN_READY = 0, BUSY = 0
  - state IDLE, CRC all ones, counter 0
- IN_READY rises combinationally in the first cycle after RESET_N deasserts.
- Latency: an accepted input byte appears on OUT_DATA the next cycle.
- Throughput: one byte per cycle with OUT_READY held high.
- Frame of N payload bytes produces max(N, MIN_LEN) + 4 output bytes.
- With continuous input and OUT_READY high, back-to-back frames leave zero idle cycles on the output. The next frame's first byte is accepted in the cycle after FCS byte 3 is loaded.
- IN_VALID gaps in DATA create output bubbles (OUT_VALID = 0) but do not stall the CRC.
- OUT_READY low stalls everything: no load, no CRC update, no counter or state change.
- Reset mid-frame: the partial frame is discarded with no FCS and no OUT_LAST. The next frame after reset starts with a clean CRC.
- BUSY is set on the first input transfer of a frame. It clears in the cycle after the OUT_LAST transfer unless a new frame's byte was accepted in that same transfer cycle.

## Test plan
- MIN_LEN=0, send ASCII "123456789" (0x31..0x39), OUT_READY=1 -> 13 output bytes: the 9 data bytes, then 0x26, 0x39, 0xF4, 0xCB; OUT_LAST only on 0xCB.
- MIN_LEN=60, 1-byte frame 0xAA -> 0xAA, 59 × 0x00, then 4 FCS bytes matching the reference model; 64 output bytes; IN_READY low for 63 cycles after the accept.
- MIN_LEN=60, 64-byte frame -> no padding, 68 output bytes; FCS matches model.
- "123456789" with OUT_READY randomly low 50 % -> OUT_DATA/OUT_LAST stable during stalls; byte sequence identical to test 1.
- Three back-to-back 60-byte frames, IN_VALID and OUT_READY constantly high -> 192 contiguous output bytes, OUT_LAST at bytes 64, 128 and 192; each FCS correct.
- RESET_N pulsed low after byte 5 of a frame, then "123456789" sent with MIN_LEN=0 -> outputs 0 immediately on reset; the following frame's FCS is 0x26, 0x39, 0xF4, 0xCB.
